// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: result-source select and load size.
package writeback_stage_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_WORD2 = 2'b11;

endpackage

// File: rtl/writeback_stage_load_extender.sv
// Picks the addressed byte/half out of the loaded word and sign- or zero-extends it.
module load_extender
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] read_data_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      load_size_i,
  input  logic            load_unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = read_data_i[{addr_lo_i, 3'b000} +: 8];
    // Half lanes are aligned; the low address bit does not shift the pair.
    halfLane = read_data_i[{addr_lo_i[1], 4'b0000} +: 16];
    data_o   = read_data_i;
    case (load_size_i)
      SIZE_BYTE: data_o = {{(XLEN-8){~load_unsigned_i & byteLane[7]}}, byteLane};
      SIZE_HALF: data_o = {{(XLEN-16){~load_unsigned_i & halfLane[15]}}, halfLane};
      default:   data_o = read_data_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline register: selects the result, registers it with one cycle
// latency, and counts retired entries.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic                  m_reg_write,
  input  logic [1:0]            m_result_sel,
  input  logic [1:0]            m_load_size,
  input  logic                  m_load_unsigned,
  input  logic [1:0]            m_addr_lo,
  input  logic [XLEN-1:0]       m_alu_result,
  input  logic [XLEN-1:0]       m_read_data,
  input  logic [XLEN-1:0]       m_pc_plus4,
  input  logic [XLEN-1:0]       m_imm,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  w_valid,
  output logic                  w_reg_write,
  output logic [REG_ADDR_W-1:0] w_rd,
  output logic [XLEN-1:0]       w_result,
  output logic [CNT_W-1:0]      retire_count
);

  logic [XLEN-1:0]       loadData;
  logic [XLEN-1:0]       result_d;
  logic                  regWrite_d;

  logic                  valid_q;
  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       result_q;
  logic [CNT_W-1:0]      count_q;

  load_extender #(.XLEN(XLEN)) u_load_extender (
    .read_data_i     (m_read_data),
    .addr_lo_i       (m_addr_lo),
    .load_size_i     (m_load_size),
    .load_unsigned_i (m_load_unsigned),
    .data_o          (loadData)
  );

  always_comb begin
    result_d = m_alu_result;
    case (m_result_sel)
      SEL_LOAD: result_d = loadData;
      SEL_PC4:  result_d = m_pc_plus4;
      SEL_IMM:  result_d = m_imm;
      default:  result_d = m_alu_result;
    endcase
    // x0 is hardwired to zero, so writes to it never reach the register file.
    regWrite_d = m_valid & m_reg_write & (m_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regWrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regWrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= m_valid;
      regWrite_q <= regWrite_d;
      rd_q       <= m_rd;
      result_q   <= result_d;
      if (m_valid) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign w_valid      = valid_q;
  assign w_reg_write  = regWrite_q;
  assign w_rd         = rd_q;
  assign w_result     = result_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage, built with a 4-bit retire counter so wrap is reachable.
module tb_writeback_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_valid, m_reg_write, m_load_unsigned;
  logic [1:0]      m_result_sel, m_load_size, m_addr_lo;
  logic [XLEN-1:0] m_alu_result, m_read_data, m_pc_plus4, m_imm;
  logic [RW-1:0]   m_rd;
  logic            stall, flush;
  logic            w_valid, w_reg_write;
  logic [RW-1:0]   w_rd;
  logic [XLEN-1:0] w_result;
  logic [CW-1:0]   retire_count;

  int vectors = 0;
  int miscompares = 0;

  writeback_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_result_sel(m_result_sel),
    .m_load_size(m_load_size), .m_load_unsigned(m_load_unsigned), .m_addr_lo(m_addr_lo),
    .m_alu_result(m_alu_result), .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
    .m_imm(m_imm), .m_rd(m_rd), .stall(stall), .flush(flush),
    .w_valid(w_valid), .w_reg_write(w_reg_write), .w_rd(w_rd),
    .w_result(w_result), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] sel,
                               input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                               input logic [31:0] data, input logic [RW-1:0] rd);
    m_valid = v; m_reg_write = we; m_result_sel = sel; m_load_size = sz;
    m_load_unsigned = uns; m_addr_lo = lo; m_rd = rd;
    m_alu_result = data; m_read_data = data; m_pc_plus4 = data; m_imm = data;
  endtask

  task automatic checkAll(input string tag, input logic v, input logic we,
                          input logic [RW-1:0] rd, input logic [31:0] res, input logic [CW-1:0] cnt);
    checkOutput({tag, ".w_valid"}, 64'(v), 64'(w_valid));
    checkOutput({tag, ".w_reg_write"}, 64'(w_reg_write), 64'(we));
    checkOutput({tag, ".w_rd"}, 64'(w_rd), 64'(rd));
    checkOutput({tag, ".w_result"}, 64'(w_result), 64'(res));
    checkOutput({tag, ".retire_count"}, 64'(retire_count), 64'(cnt));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 32'hDEAD_0001, 5'd1);
    tick();
    checkAll("reset", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'd3, 32'h80FF_1234, 5'd3);
    tick();
    checkAll("lb_signed", 1'b1, 1'b1, 5'd3, 32'hFFFF_FF80, 4'd1);

    applyStimulus(1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 2'd2, 32'h9ABC_0000, 5'd7);
    tick();
    checkAll("lhu_hi", 1'b1, 1'b1, 5'd7, 32'h0000_9ABC, 4'd2);

    applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 2'd1, 32'h1234_80CD, 5'd8);
    tick();
    checkOutput("lbu_lane1.w_result", 64'(w_result), 64'h0000_0080);

    applyStimulus(1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'd1, 32'h1234_F00D, 5'd8);
    tick();
    checkOutput("lh_lo_odd.w_result", 64'(w_result), 64'hFFFF_F00D);

    applyStimulus(1'b1, 1'b1, 2'b01, 2'b11, 1'b1, 2'd3, 32'hDEAD_BEEF, 5'd8);
    tick();
    checkAll("lw_sz11", 1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 4'd5);

    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_1234, 5'd0);
    tick();
    checkAll("x0_write", 1'b1, 1'b0, 5'd0, 32'h0000_1234, 4'd6);

    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'd0, 32'hCAFE_F00D, 5'd9);
    tick();
    checkAll("imm_nowrite", 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 4'd7);

    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_0055, 5'd4);
    tick();
    checkAll("bubble", 1'b0, 1'b0, 5'd4, 32'h0000_0055, 4'd7);

    applyStimulus(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'd0, 32'h0000_0104, 5'd5);
    tick();
    checkAll("pc4", 1'b1, 1'b1, 5'd5, 32'h0000_0104, 4'd8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'(i), 2'b10, 1'b0, 2'(i), 32'h7700_0000 + 32'(i), 5'(10 + i));
      tick();
      checkAll($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd5, 32'h0000_0104, 4'd8);
    end

    flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_0099, 5'd6);
    tick();
    checkOutput("flush.w_valid", 64'(w_valid), 64'd0);
    checkOutput("flush.w_reg_write", 64'(w_reg_write), 64'd0);
    checkOutput("flush.retire_count", 64'(retire_count), 64'd8);
    stall = 1'b0; flush = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'd0, 32'h0000_0011, 5'd2);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("prewrap.retire_count", 64'(retire_count), 64'd15);
    tick();
    checkOutput("wrap.retire_count", 64'(retire_count), 64'd0);
    tick();
    checkOutput("postwrap.retire_count", 64'(retire_count), 64'd1);

    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'd0, 32'h0000_00AA, 5'd12);
    tick();
    checkAll("midrst", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'd0, 32'h0000_0077, 5'd2);
    tick();
    checkAll("after_rst", 1'b1, 1'b1, 5'd2, 32'h0000_0077, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32: datapath width in bits.
REQ-002 SHALL provide parameter REG_ADDR_W, default 5: register address width.
REQ-003 SHALL provide parameter CNT_W, default 64: retire counter width.
REQ-004 SHALL provide clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL provide m_valid  in  1  MEM-stage entry valid.
REQ-007 SHALL provide m_reg_write  in  1  entry writes the register file.
REQ-008 SHALL provide m_result_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-009 SHALL provide m_load_size  in  2  00 byte, 01 half, 10 word, 11 word.
REQ-010 SHALL provide m_load_unsigned  in  1  zero-extend when 1, sign-extend when 0.
REQ-011 SHALL provide m_addr_lo  in  2  byte offset of load address.
REQ-012 SHALL provide m_alu_result, m_read_data, m_pc_plus4, m_imm  in  XLEN each  result sources.
REQ-013 SHALL provide m_rd  in  REG_ADDR_W  destination register.
REQ-014 SHALL provide stall  in  1  hold WB register contents.
REQ-015 SHALL provide flush  in  1  load a bubble into WB register.
REQ-016 SHALL provide w_valid  out  1; w_reg_write  out  1; w_rd  out  REG_ADDR_W; w_result  out  XLEN  registered writeback outputs.
REQ-017 SHALL provide retire_count  out  CNT_W  count of entries accepted into WB.

Function
REQ-018 SHALL compute the selected result combinationally from m_* inputs and register it; latency exactly 1 cycle from input to w_* outputs.
REQ-019 Load extraction SHALL be: byte = m_read_data byte lane m_addr_lo; half = lane pair selected by m_addr_lo[1] (m_addr_lo[0] ignored); word = m_read_data unmodified.
REQ-020 Extended byte/half SHALL be sign- or zero-extended to XLEN per m_load_unsigned; m_load_unsigned ignored for word.
REQ-021 Captured w_reg_write SHALL equal m_valid AND m_reg_write AND (m_rd != 0); writes to x0 are suppressed.
REQ-022 Each edge priority SHALL be: rst, then flush, then stall, then normal capture.
REQ-023 flush SHALL set w_valid=0 and w_reg_write=0; w_rd and w_result may hold any value.
REQ-024 stall (without flush) SHALL hold all w_* outputs and retire_count unchanged.
REQ-025 Normal capture SHALL load w_valid=m_valid plus all derived fields, including when m_valid=0 (bubble passes through).
REQ-026 retire_count SHALL increment by 1 on each normal capture with m_valid=1, wrapping modulo 2^CNT_W with no saturation.
REQ-027 Flushed or stalled cycles SHALL NOT change retire_count.
REQ-028 w_result SHALL be driven only from the register, never combinationally from inputs.

Reset
REQ-029 On rst=1 at a rising edge, w_valid, w_reg_write SHALL be 0, w_rd 0, w_result 0, retire_count 0.
REQ-030 rst asserted mid-stream SHALL discard the in-flight entry; the first capture after release behaves as REQ-025.

Structure
REQ-031 Result-select and load-size encodings SHALL live as named constants in the shared core package.
REQ-032 Byte/half selection and extension SHALL be one sub-module, load_extender, parametrised by XLEN.
REQ-033 Block SHALL contain no latches and a single always block for the WB register and counter.

Verification
REQ-034 sel=01, size=00, unsigned=0, addr_lo=3, read_data=0x80FF_1234 -> next cycle w_result=0xFFFF_FF80.
REQ-035 sel=01, size=01, unsigned=1, addr_lo=2, read_data=0x9ABC_0000 -> w_result=0x0000_9ABC.
REQ-036 valid=1, reg_write=1, rd=0, sel=00, alu=0x1234 -> w_valid=1, w_reg_write=0, retire_count+1.
REQ-037 Capture rd=5, pc_plus4=0x104 (sel=10); then stall 3 cycles with changing inputs -> w_rd=5, w_result=0x104 held, count unchanged.
REQ-038 stall=1 and flush=1 together with valid entry -> w_valid=0, w_reg_write=0, count unchanged.
REQ-039 Preload retire_count near wrap (CNT_W=4 build: 15 captures) then one valid capture -> retire_count=0; rst mid-run -> all outputs 0.
